// File: rtl/sb_issue_ctrl_if.sv
// Issue/writeback/commit bundle for the scoreboard entry controller.
// master = decode/FU/commit side, slave = sb_issue_ctrl.
interface sb_issue_ctrl_if #(
    parameter int unsigned NR_ENTRIES = 8
);
    localparam int unsigned PTR_W = $clog2(NR_ENTRIES);

    logic                        flush_i;
    logic                        issue_valid_i;
    logic [4:0]                  issue_rd_i;
    logic                        issue_we_i;
    logic                        issue_ready_o;
    logic [PTR_W-1:0]            issue_idx_o;
    logic                        wb_valid_i;
    logic [PTR_W-1:0]            wb_idx_i;
    logic                        commit_valid_o;
    logic [PTR_W-1:0]            commit_idx_o;
    logic [4:0]                  commit_rd_o;
    logic                        commit_we_o;
    logic                        commit_ack_i;
    logic [NR_ENTRIES-1:0][4:0]  rd_o;
    logic [NR_ENTRIES-1:0]       still_issued_o;
    logic [PTR_W-1:0]            issue_pointer_o;
    logic [PTR_W:0]              count_o;

    modport master (
        output flush_i, issue_valid_i, issue_rd_i, issue_we_i,
               wb_valid_i, wb_idx_i, commit_ack_i,
        input  issue_ready_o, issue_idx_o, commit_valid_o, commit_idx_o,
               commit_rd_o, commit_we_o, rd_o, still_issued_o,
               issue_pointer_o, count_o
    );

    modport slave (
        input  flush_i, issue_valid_i, issue_rd_i, issue_we_i,
               wb_valid_i, wb_idx_i, commit_ack_i,
        output issue_ready_o, issue_idx_o, commit_valid_o, commit_idx_o,
               commit_rd_o, commit_we_o, rd_o, still_issued_o,
               issue_pointer_o, count_o
    );
endinterface

// File: rtl/sb_issue_ctrl.sv
// Scoreboard entry controller: in-order allocate, FREE/ISSUED/DONE tracking, in-order retire.
// Optional macro SB_WB_BYPASS_EN makes a writeback visible to hazard/commit in its own cycle.
module sb_issue_ctrl #(
    parameter int unsigned NR_ENTRIES = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    sb_issue_ctrl_if.slave sb
);
    localparam int unsigned    PTR_W    = $clog2(NR_ENTRIES);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(NR_ENTRIES);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_ISSUED = 2'd1,
        S_DONE   = 2'd2
    } entry_state_e;

    entry_state_e               r_state     [NR_ENTRIES];
    entry_state_e               w_state_nxt [NR_ENTRIES];
    logic [NR_ENTRIES-1:0][4:0] r_rd, w_rd_nxt;
    logic [NR_ENTRIES-1:0]      r_we, w_we_nxt;
    logic [PTR_W-1:0]           r_head, r_tail, w_head_nxt, w_tail_nxt;
    logic [PTR_W:0]             r_count, w_count_nxt;
    logic [NR_ENTRIES-1:0]      w_wb_hit;
    logic                       w_issue_fire;
    logic                       w_commit_fire;
    logic                       w_head_ready;

    always_comb begin
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            w_wb_hit[i] = sb.wb_valid_i && (sb.wb_idx_i == PTR_W'(i)) &&
                          (r_state[i] == S_ISSUED);
        end
    end

    // Readiness uses the registered count only, so a full queue never falls through.
    assign sb.issue_ready_o = (r_count < FULL_CNT);
    assign w_issue_fire     = sb.issue_valid_i && sb.issue_ready_o;

`ifdef SB_WB_BYPASS_EN
    assign w_head_ready = (r_state[r_head] == S_DONE) || w_wb_hit[r_head];
`else
    assign w_head_ready = (r_state[r_head] == S_DONE);
`endif

    assign sb.commit_valid_o  = (r_count != '0) && w_head_ready;
    assign w_commit_fire      = sb.commit_valid_o && sb.commit_ack_i;
    assign sb.commit_idx_o    = r_head;
    assign sb.commit_rd_o     = r_rd[r_head];
    assign sb.commit_we_o     = r_we[r_head];
    assign sb.issue_idx_o     = r_tail;
    assign sb.issue_pointer_o = r_tail;
    assign sb.count_o         = r_count;
    assign sb.rd_o            = r_rd;

    always_comb begin
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
`ifdef SB_WB_BYPASS_EN
            sb.still_issued_o[i] = (r_state[i] == S_ISSUED) && r_we[i] && !w_wb_hit[i];
`else
            sb.still_issued_o[i] = (r_state[i] == S_ISSUED) && r_we[i];
`endif
        end
    end

    always_comb begin
        w_rd_nxt    = r_rd;
        w_we_nxt    = r_we;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            w_state_nxt[i] = r_state[i];
        end

        if (sb.flush_i) begin
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                w_state_nxt[i] = S_FREE;
            end
            w_head_nxt  = '0;
            w_tail_nxt  = '0;
            w_count_nxt = '0;
        end else begin
            // Commit is checked first: with bypass the head may retire straight from ISSUED.
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                if (w_commit_fire && (r_head == PTR_W'(i))) begin
                    w_state_nxt[i] = S_FREE;
                end else if (w_issue_fire && (r_tail == PTR_W'(i))) begin
                    w_state_nxt[i] = S_ISSUED;
                    w_rd_nxt[i]    = sb.issue_rd_i;
                    w_we_nxt[i]    = sb.issue_we_i;
                end else if (w_wb_hit[i]) begin
                    w_state_nxt[i] = S_DONE;
                end
            end
            if (w_issue_fire)  w_tail_nxt = r_tail + PTR_W'(1);
            if (w_commit_fire) w_head_nxt = r_head + PTR_W'(1);
            unique case ({w_issue_fire, w_commit_fire})
                2'b10:   w_count_nxt = r_count + (PTR_W+1)'(1);
                2'b01:   w_count_nxt = r_count - (PTR_W+1)'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                r_state[i] <= S_FREE;
            end
            r_rd    <= '0;
            r_we    <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                r_state[i] <= w_state_nxt[i];
            end
            r_rd    <= w_rd_nxt;
            r_we    <= w_we_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
        end
    end
endmodule

// File: tb/tb_sb_issue_ctrl.sv
// Directed self-checking bench for sb_issue_ctrl with an 8-entry scoreboard.
module tb_sb_issue_ctrl;
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    sb_issue_ctrl_if #(.NR_ENTRIES(8)) bus ();

    sb_issue_ctrl #(.NR_ENTRIES(8)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .sb     (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush_i       = 1'b0;
        bus.issue_valid_i = 1'b0;
        bus.issue_rd_i    = 5'd0;
        bus.issue_we_i    = 1'b0;
        bus.wb_valid_i    = 1'b0;
        bus.wb_idx_i      = 3'd0;
        bus.commit_ack_i  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
    endtask

    task automatic issue_one(input logic [4:0] rd);
        bus.issue_valid_i = 1'b1;
        bus.issue_rd_i    = rd;
        bus.issue_we_i    = 1'b1;
        step();
        bus.issue_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.issue_ready_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.issue_ready_o); else n_pass++;
        n_checks++; if (bus.count_o !== 4'd0) $display("FAIL reset_count got=%0d exp=0", bus.count_o); else n_pass++;
        n_checks++; if (bus.commit_valid_o !== 1'b0) $display("FAIL reset_commit_valid got=%b exp=0", bus.commit_valid_o); else n_pass++;
        n_checks++; if (bus.still_issued_o !== 8'h00) $display("FAIL reset_still_issued got=%h exp=00", bus.still_issued_o); else n_pass++;
        n_checks++; if (bus.rd_o !== 40'h0) $display("FAIL reset_rd got=%h exp=0", bus.rd_o); else n_pass++;
        n_checks++; if (bus.issue_pointer_o !== 3'd0) $display("FAIL reset_ptr got=%0d exp=0", bus.issue_pointer_o); else n_pass++;
    endtask

    task automatic test_issue_single();
        do_reset();
        bus.issue_valid_i = 1'b1;
        bus.issue_rd_i    = 5'd5;
        bus.issue_we_i    = 1'b1;
        #1;
        n_checks++; if (bus.issue_idx_o !== 3'd0) $display("FAIL single_idx got=%0d exp=0", bus.issue_idx_o); else n_pass++;
        step();
        bus.issue_valid_i = 1'b0;
        #1;
        n_checks++; if (bus.still_issued_o !== 8'h01) $display("FAIL single_still got=%h exp=01", bus.still_issued_o); else n_pass++;
        n_checks++; if (bus.rd_o[0] !== 5'd5) $display("FAIL single_rd0 got=%0d exp=5", bus.rd_o[0]); else n_pass++;
        n_checks++; if (bus.issue_pointer_o !== 3'd1) $display("FAIL single_ptr got=%0d exp=1", bus.issue_pointer_o); else n_pass++;
        n_checks++; if (bus.count_o !== 4'd1) $display("FAIL single_count got=%0d exp=1", bus.count_o); else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) issue_one(5'(i + 1));
        bus.issue_valid_i = 1'b1;
        bus.issue_rd_i    = 5'd31;
        #1;
        n_checks++; if (bus.count_o !== 4'd8) $display("FAIL full_count got=%0d exp=8", bus.count_o); else n_pass++;
        n_checks++; if (bus.issue_ready_o !== 1'b0) $display("FAIL full_ready got=%b exp=0", bus.issue_ready_o); else n_pass++;
        step();
        n_checks++; if (bus.count_o !== 4'd8) $display("FAIL full_9th_count got=%0d exp=8", bus.count_o); else n_pass++;
        n_checks++; if (bus.issue_pointer_o !== 3'd0) $display("FAIL full_9th_ptr got=%0d exp=0", bus.issue_pointer_o); else n_pass++;
        bus.wb_valid_i = 1'b1;
        bus.wb_idx_i   = 3'd0;
        step();
        bus.wb_valid_i = 1'b0;
        #1;
        n_checks++; if (bus.commit_valid_o !== 1'b1) $display("FAIL full_commit_valid got=%b exp=1", bus.commit_valid_o); else n_pass++;
        n_checks++; if (bus.commit_rd_o !== 5'd1) $display("FAIL full_commit_rd got=%0d exp=1", bus.commit_rd_o); else n_pass++;
        bus.commit_ack_i = 1'b1;
        #1;
        n_checks++; if (bus.issue_ready_o !== 1'b0) $display("FAIL full_no_fallthrough got=%b exp=0", bus.issue_ready_o); else n_pass++;
        step();
        bus.commit_ack_i = 1'b0;
        #1;
        n_checks++; if (bus.count_o !== 4'd7) $display("FAIL full_after_commit_count got=%0d exp=7", bus.count_o); else n_pass++;
        n_checks++; if (bus.issue_ready_o !== 1'b1) $display("FAIL full_after_commit_ready got=%b exp=1", bus.issue_ready_o); else n_pass++;
        n_checks++; if (bus.commit_idx_o !== 3'd1) $display("FAIL full_head got=%0d exp=1", bus.commit_idx_o); else n_pass++;
        step();
        bus.issue_valid_i = 1'b0;
        #1;
        n_checks++; if (bus.count_o !== 4'd8) $display("FAIL full_refill_count got=%0d exp=8", bus.count_o); else n_pass++;
        n_checks++; if (bus.rd_o[0] !== 5'd31) $display("FAIL full_refill_rd got=%0d exp=31", bus.rd_o[0]); else n_pass++;
    endtask

    task automatic test_out_of_order();
        do_reset();
        issue_one(5'd10);
        issue_one(5'd11);
        issue_one(5'd12);
        bus.wb_valid_i = 1'b1; bus.wb_idx_i = 3'd2;
        step();
        bus.wb_valid_i = 1'b0;
        #1;
        n_checks++; if (bus.commit_valid_o !== 1'b0) $display("FAIL ooo_idx2_only got=%b exp=0", bus.commit_valid_o); else n_pass++;
        n_checks++; if (bus.still_issued_o !== 8'h03) $display("FAIL ooo_still_a got=%h exp=03", bus.still_issued_o); else n_pass++;
        bus.wb_valid_i = 1'b1; bus.wb_idx_i = 3'd0;
        step();
        bus.wb_valid_i = 1'b0;
        #1;
        n_checks++; if (bus.commit_valid_o !== 1'b1) $display("FAIL ooo_idx0_valid got=%b exp=1", bus.commit_valid_o); else n_pass++;
        n_checks++; if (bus.commit_rd_o !== 5'd10) $display("FAIL ooo_idx0_rd got=%0d exp=10", bus.commit_rd_o); else n_pass++;
        bus.commit_ack_i = 1'b1;
        step();
        bus.commit_ack_i = 1'b0;
        #1;
        n_checks++; if (bus.commit_valid_o !== 1'b0) $display("FAIL ooo_head1_wait got=%b exp=0", bus.commit_valid_o); else n_pass++;
        n_checks++; if (bus.commit_idx_o !== 3'd1) $display("FAIL ooo_head1_idx got=%0d exp=1", bus.commit_idx_o); else n_pass++;
        bus.wb_valid_i = 1'b1; bus.wb_idx_i = 3'd5;
        step();
        bus.wb_valid_i = 1'b0;
        #1;
        n_checks++; if (bus.count_o !== 4'd2) $display("FAIL ooo_free_wb_count got=%0d exp=2", bus.count_o); else n_pass++;
        n_checks++; if (bus.commit_valid_o !== 1'b0) $display("FAIL ooo_free_wb_valid got=%b exp=0", bus.commit_valid_o); else n_pass++;
        bus.wb_valid_i = 1'b1; bus.wb_idx_i = 3'd1;
        step();
        bus.wb_valid_i = 1'b0;
        #1;
        n_checks++; if (bus.commit_rd_o !== 5'd11 || bus.commit_valid_o !== 1'b1) $display("FAIL ooo_idx1 got=%b/%0d exp=1/11", bus.commit_valid_o, bus.commit_rd_o); else n_pass++;
        bus.commit_ack_i = 1'b1;
        step();
        #1;
        n_checks++; if (bus.commit_rd_o !== 5'd12 || bus.commit_idx_o !== 3'd2) $display("FAIL ooo_idx2 got=%0d/%0d exp=2/12", bus.commit_idx_o, bus.commit_rd_o); else n_pass++;
        step();
        bus.commit_ack_i = 1'b0;
        #1;
        n_checks++; if (bus.count_o !== 4'd0 || bus.commit_valid_o !== 1'b0) $display("FAIL ooo_empty got=%0d/%b exp=0/0", bus.count_o, bus.commit_valid_o); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int j = 0; j < 7; j++) begin
            issue_one(5'(j));
            bus.wb_valid_i = 1'b1; bus.wb_idx_i = 3'(j);
            step();
            bus.wb_valid_i = 1'b0;
            bus.commit_ack_i = 1'b1;
            step();
            bus.commit_ack_i = 1'b0;
        end
        #1;
        n_checks++; if (bus.issue_pointer_o !== 3'd7 || bus.count_o !== 4'd0) $display("FAIL wrap_setup got=%0d/%0d exp=7/0", bus.issue_pointer_o, bus.count_o); else n_pass++;
        issue_one(5'd20);
        bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd21;
        bus.wb_valid_i = 1'b1;    bus.wb_idx_i = 3'd7;
        step();
        for (int k = 0; k < 10; k++) begin
            bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'(22 + k);
            bus.wb_valid_i = 1'b1;    bus.wb_idx_i = 3'(k % 8);
            bus.commit_ack_i = 1'b1;
            #1;
            n_checks++; if (bus.commit_valid_o !== 1'b1 || bus.commit_rd_o !== 5'(20 + k) || bus.commit_idx_o !== 3'((7 + k) % 8))
                $display("FAIL wrap_commit_%0d got=%b/%0d/%0d exp=1/%0d/%0d", k, bus.commit_valid_o, bus.commit_idx_o, bus.commit_rd_o, (7 + k) % 8, 20 + k);
            else n_pass++;
            step();
            n_checks++; if (bus.count_o !== 4'd2) $display("FAIL wrap_count_%0d got=%0d exp=2", k, bus.count_o); else n_pass++;
        end
        idle_inputs();
        #1;
        n_checks++; if (bus.issue_pointer_o !== 3'd3) $display("FAIL wrap_tail got=%0d exp=3", bus.issue_pointer_o); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) issue_one(5'(4 + i));
        bus.wb_valid_i = 1'b1; bus.wb_idx_i = 3'd0;
        step();
        bus.flush_i = 1'b1;
        bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd9; bus.issue_we_i = 1'b1;
        bus.wb_valid_i = 1'b1; bus.wb_idx_i = 3'd3;
        bus.commit_ack_i = 1'b1;
        #1;
        n_checks++; if (bus.commit_valid_o !== 1'b1) $display("FAIL flush_pre_commit got=%b exp=1", bus.commit_valid_o); else n_pass++;
        n_checks++; if (bus.rd_o[3] !== 5'd7) $display("FAIL flush_pre_rd3 got=%0d exp=7", bus.rd_o[3]); else n_pass++;
`ifdef SB_WB_BYPASS_EN
        n_checks++; if (bus.still_issued_o !== 8'h06) $display("FAIL flush_bypass_still got=%h exp=06", bus.still_issued_o); else n_pass++;
`else
        n_checks++; if (bus.still_issued_o !== 8'h0E) $display("FAIL flush_nobypass_still got=%h exp=0e", bus.still_issued_o); else n_pass++;
`endif
        step();
        idle_inputs();
        #1;
        n_checks++; if (bus.count_o !== 4'd0) $display("FAIL flush_count got=%0d exp=0", bus.count_o); else n_pass++;
        n_checks++; if (bus.issue_pointer_o !== 3'd0 || bus.commit_idx_o !== 3'd0) $display("FAIL flush_ptrs got=%0d/%0d exp=0/0", bus.issue_pointer_o, bus.commit_idx_o); else n_pass++;
        n_checks++; if (bus.still_issued_o !== 8'h00) $display("FAIL flush_still got=%h exp=00", bus.still_issued_o); else n_pass++;
        n_checks++; if (bus.commit_valid_o !== 1'b0 || bus.issue_ready_o !== 1'b1) $display("FAIL flush_hs got=%b/%b exp=0/1", bus.commit_valid_o, bus.issue_ready_o); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        issue_one(5'd3);
        issue_one(5'd4);
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++; if (bus.count_o !== 4'd0 || bus.still_issued_o !== 8'h00) $display("FAIL async_reset got=%0d/%h exp=0/00", bus.count_o, bus.still_issued_o); else n_pass++;
        n_checks++; if (bus.issue_pointer_o !== 3'd0 || bus.rd_o !== 40'h0) $display("FAIL async_reset_state got=%0d/%h exp=0/0", bus.issue_pointer_o, bus.rd_o); else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_issue_single();
        test_full();
        test_out_of_order();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
